// File: rtl/mic1_microsequencer.sv
// MIC-1 microprogram sequencer: holds the MPC, fetches into the MIR, forms the next address
// from NEXT_ADDRESS/JAM/JMPC, and stalls on memory or halts on a halt address or bad ALU code.
module mic1_microsequencer #(
    parameter logic [8:0] RESET_ADDR = 9'h000,
    parameter logic [8:0] HALT_ADDR  = 9'h1FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [8:0]  cs_addr,
    input  logic [35:0] cs_data,
    input  logic [7:0]  mbr,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        mem_busy,
    output logic [35:0] mir,
    output logic        mir_valid,
    output logic [5:0]  alu_ctrl,
    output logic        n_flag,
    output logic        z_flag,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFetch = 3'd1;
    localparam logic [2:0] StExec  = 3'd2;
    localparam logic [2:0] StStall = 3'd3;
    localparam logic [2:0] StHalt  = 3'd4;

    localparam logic [5:0] AluZero = 6'b010000;

    logic [2:0]  state_q, state_d;
    logic [8:0]  mpc_q, mpc_d;
    logic [35:0] mir_q, mir_d;
    logic        n_q, n_d;
    logic        z_q, z_d;
    logic        err_q, err_d;
    logic        alu_legal;
    logic [8:0]  next_mpc;

    always_comb begin
        unique case (mir_q[21:16])
            6'b011000, 6'b010100, 6'b011010, 6'b101100,
            6'b111100, 6'b111101, 6'b111001, 6'b110101,
            6'b111111, 6'b110110, 6'b111011, 6'b001100,
            6'b011100, 6'b010000, 6'b110001, 6'b110010: alu_legal = 1'b1;
            default:                                    alu_legal = 1'b0;
        endcase
    end

    // Bitwise OR composition, no carry between the JAM bit and the JMPC byte.
    always_comb begin
        next_mpc[8]   = mir_q[35] | (mir_q[25] & alu_n) | (mir_q[24] & alu_z);
        next_mpc[7:0] = mir_q[34:27] | (mir_q[26] ? mbr : 8'h00);
    end

    always_comb begin
        state_d = state_q;
        mpc_d   = mpc_q;
        mir_d   = mir_q;
        n_d     = n_q;
        z_d     = z_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                mpc_d = RESET_ADDR;
                if (start) begin
                    state_d = StFetch;
                    err_d   = 1'b0;
                end
            end
            StFetch: begin
                mir_d   = cs_data;
                state_d = StExec;
            end
            StExec: begin
                n_d = alu_n;
                z_d = alu_z;
                if (!alu_legal) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end else begin
                    mpc_d = next_mpc;
                    if (next_mpc == HALT_ADDR) begin
                        state_d = StHalt;
                    end else if (mem_busy) begin
                        state_d = StStall;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StStall: begin
                if (!mem_busy) begin
                    state_d = StFetch;
                end
            end
            StHalt: begin
                if (start) begin
                    state_d = StFetch;
                    mpc_d   = RESET_ADDR;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                mpc_d   = RESET_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mpc_q   <= RESET_ADDR;
            mir_q   <= 36'h0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
            mir_q   <= mir_d;
            n_q     <= n_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        cs_addr   = mpc_q;
        mir       = mir_q;
        mir_valid = (state_q == StExec);
        alu_ctrl  = (mir_valid && alu_legal) ? mir_q[21:16] : AluZero;
        n_flag    = n_q;
        z_flag    = z_q;
        busy      = (state_q == StFetch) || (state_q == StExec) || (state_q == StStall);
        halted    = (state_q == StHalt);
        err       = err_q;
    end

endmodule

// File: tb/tb_mic1_microsequencer.sv
// Directed bench for mic1_microsequencer: expectations are queued as each step is driven
// and popped when the corresponding output is sampled.
module tb_mic1_microsequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  cs_addr;
    logic [35:0] cs_data;
    logic [7:0]  mbr;
    logic        alu_n;
    logic        alu_z;
    logic        mem_busy;
    logic [35:0] mir;
    logic        mir_valid;
    logic [5:0]  alu_ctrl;
    logic        n_flag;
    logic        z_flag;
    logic        busy;
    logic        halted;
    logic        err;

    logic [35:0] rom [0:511];
    assign cs_data = rom[cs_addr];

    mic1_microsequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cs_addr   (cs_addr),
        .cs_data   (cs_data),
        .mbr       (mbr),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .mem_busy  (mem_busy),
        .mir       (mir),
        .mir_valid (mir_valid),
        .alu_ctrl  (alu_ctrl),
        .n_flag    (n_flag),
        .z_flag    (z_flag),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    string       exp_tag[$];
    logic [35:0] exp_val[$];

    function automatic logic [35:0] mk(input logic [8:0] nxt, input logic jmpc,
                                       input logic jamz, input logic [5:0] alu);
        return {nxt, jmpc, 1'b0, jamz, 2'b00, alu, 16'h0000};
    endfunction

    task automatic push(input string tag, input logic [35:0] val);
        exp_tag.push_back(tag);
        exp_val.push_back(val);
    endtask

    task automatic pop_check(input logic [35:0] obs);
        string       tag;
        logic [35:0] e;
        tag = exp_tag.pop_front();
        e   = exp_val.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic expect_now(input string tag, input logic [35:0] obs, input logic [35:0] e);
        push(tag, e);
        pop_check(obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 36'h0;
        rom[9'h000] = mk(9'h002, 1'b0, 1'b0, 6'b111100);
        rom[9'h002] = mk(9'h005, 1'b0, 1'b1, 6'b010100);
        rom[9'h105] = mk(9'h005, 1'b0, 1'b1, 6'b010100);
        rom[9'h005] = mk(9'h100, 1'b1, 1'b0, 6'b011000);
        rom[9'h15A] = mk(9'h000, 1'b1, 1'b0, 6'b110101);
        rom[9'h0FF] = mk(9'h010, 1'b0, 1'b0, 6'b111101);
        rom[9'h010] = mk(9'h1FF, 1'b0, 1'b0, 6'b001100);

        rst = 1'b1; start = 1'b0; mbr = 8'h00; alu_n = 1'b0; alu_z = 1'b0; mem_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        expect_now("rst_cs_addr", {27'h0, cs_addr}, 36'h000);
        expect_now("rst_mir", mir, 36'h0);
        expect_now("rst_mir_valid", {35'h0, mir_valid}, 36'h0);
        expect_now("rst_alu_ctrl", {30'h0, alu_ctrl}, 36'h10);
        expect_now("rst_flags", {34'h0, n_flag, z_flag}, 36'h0);
        expect_now("rst_busy_halt_err", {33'h0, busy, halted, err}, 36'h0);

        // Start: FETCH next cycle, EXEC the cycle after.
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_now("start_fetch_addr", {27'h0, cs_addr}, 36'h000);
        expect_now("start_fetch_busy", {34'h0, busy, mir_valid}, 36'h2);
        tick();
        expect_now("exec0_valid", {35'h0, mir_valid}, 36'h1);
        expect_now("exec0_alu_ctrl", {30'h0, alu_ctrl}, 36'h3C);
        expect_now("exec0_mir", mir, rom[9'h000]);
        tick();
        expect_now("next_after_000", {27'h0, cs_addr}, 36'h002);
        expect_now("fetch_not_valid", {35'h0, mir_valid}, 36'h0);

        // JAMZ taken then not taken.
        tick();
        alu_z = 1'b1;
        expect_now("exec002_valid", {35'h0, mir_valid}, 36'h1);
        tick();
        expect_now("jamz_taken", {27'h0, cs_addr}, 36'h105);
        expect_now("z_flag_set", {35'h0, z_flag}, 36'h1);
        tick();
        alu_z = 1'b0;
        tick();
        expect_now("jamz_not_taken", {27'h0, cs_addr}, 36'h005);
        expect_now("z_flag_clr", {35'h0, z_flag}, 36'h0);

        // JMPC ORs the MBR byte into the low address bits.
        tick();
        mbr = 8'h5A;
        tick();
        expect_now("jmpc_5a", {27'h0, cs_addr}, 36'h15A);
        tick();
        mbr = 8'hFF;
        tick();
        expect_now("jmpc_ff", {27'h0, cs_addr}, 36'h0FF);

        // Memory stall: busy high at the EXEC edge and the following two STALL edges.
        tick();
        mem_busy = 1'b1;
        expect_now("exec0ff_valid", {35'h0, mir_valid}, 36'h1);
        tick();
        expect_now("stall1", {26'h0, cs_addr, busy}, {26'h0, 9'h010, 1'b1});
        expect_now("stall1_valid", {35'h0, mir_valid}, 36'h0);
        tick();
        expect_now("stall2", {26'h0, cs_addr, busy}, {26'h0, 9'h010, 1'b1});
        tick();
        mem_busy = 1'b0;
        expect_now("stall3", {25'h0, cs_addr, busy, mir_valid}, {25'h0, 9'h010, 2'b10});
        tick();
        expect_now("stall_to_fetch", {34'h0, busy, mir_valid}, 36'h2);
        tick();
        expect_now("valid_after_stall", {35'h0, mir_valid}, 36'h1);
        expect_now("mir_after_stall", mir, rom[9'h010]);

        // Halt address.
        tick();
        expect_now("halt_state", {33'h0, halted, busy, err}, 36'h4);
        expect_now("halt_addr", {27'h0, cs_addr}, 36'h1FF);
        tick();
        expect_now("halt_holds", {35'h0, halted}, 36'h1);

        // Restart from halt; start in EXEC is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_now("restart_fetch", {26'h0, cs_addr, halted}, {26'h0, 9'h000, 1'b0});
        tick();
        start = 1'b1;
        expect_now("restart_exec", {35'h0, mir_valid}, 36'h1);
        tick();
        start = 1'b0;
        expect_now("start_in_exec_ignored", {25'h0, cs_addr, busy, mir_valid},
                   {25'h0, 9'h002, 2'b10});

        // Reset in the middle of EXEC.
        tick();
        expect_now("pre_rst_exec", {35'h0, mir_valid}, 36'h1);
        rst = 1'b1;
        #1;
        expect_now("rst_mid_exec", {25'h0, cs_addr, busy, mir_valid}, 36'h0);
        tick();
        rst = 1'b0;
        tick();
        expect_now("rst_idle", {33'h0, busy, halted, mir_valid}, 36'h0);

        // Illegal ALU code halts with err; start clears it.
        rom[9'h000] = mk(9'h002, 1'b0, 1'b0, 6'b000000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect_now("illegal_valid", {35'h0, mir_valid}, 36'h1);
        expect_now("illegal_alu_ctrl", {30'h0, alu_ctrl}, 36'h10);
        expect_now("illegal_mir", mir, rom[9'h000]);
        tick();
        expect_now("illegal_halt", {33'h0, halted, busy, err}, 36'h5);
        expect_now("illegal_mpc_held", {27'h0, cs_addr}, 36'h000);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_now("start_clears_err", {33'h0, halted, busy, err}, 36'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
